// File: rtl/placar_pkg.sv
// placar_pkg: shared types and helpers for the naval battle scoreboard.
//   estado_t      game state encoding driven on placar_jogo.estado
//   LINHAS        rows per column of the ship map
//   COLUNAS       columns of the ship map
//   CELULAS       total map cells (flattened index = coluna*LINHAS + linha)
//   popcount_mapa number of ships in a flattened map
//   bcd_tiros     tens/units of a 5-bit shot count
package placar_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    JOGANDO = 2'b01,
    VITORIA = 2'b10,
    DERROTA = 2'b11
  } estado_t;

  localparam int unsigned LINHAS    = 7;
  localparam int unsigned COLUNAS   = 5;
  localparam int unsigned CELULAS   = LINHAS * COLUNAS;
  localparam int unsigned CONT_W    = 6;
  localparam int unsigned TIROS_W   = 5;

  // Ship count of the whole map; 35 cells always fit in 6 bits.
  function automatic logic [CONT_W-1:0] popcount_mapa(input logic [CELULAS-1:0] v);
    logic [CONT_W-1:0] soma;
    soma = '0;
    for (int i = 0; i < CELULAS; i++) begin
      soma = soma + CONT_W'(v[i]);
    end
    return soma;
  endfunction

  // Tens and units of a value up to 31 by repeated subtraction of ten.
  function automatic logic [7:0] bcd_tiros(input logic [TIROS_W-1:0] v);
    logic [TIROS_W-1:0] resto;
    logic [3:0]         dezena;
    resto  = v;
    dezena = 4'd0;
    for (int k = 0; k < 3; k++) begin
      if (resto >= TIROS_W'(10)) begin
        resto  = resto - TIROS_W'(10);
        dezena = dezena + 4'd1;
      end
    end
    return {dezena, 4'(resto)};
  endfunction

endpackage

// File: rtl/detector_borda.sv
// detector_borda: one-bit rising-edge detector.
//   clock  system clock
//   reset  synchronous, active-high; clears the history register
//   in     level input (active-high)
//   pulse  high for the cycle in which 'in' is high and was low last cycle
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic in_q;

  // History register updated every cycle regardless of game state.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/placar_jogo.sv
// placar_jogo: shot evaluation, score and end-of-game tracker for the attack phase.
//   clock, reset          system clock, synchronous active-high reset
//   enable                high while the game is in the attack state
//   confirmar             confirm button level; edge detected internally
//   coordLinha/Coluna     target cell (row 0..6, column 0..4)
//   mapa0..mapa4          ship map, mapaN = column N, bit L = row L
//   tiros0..tiros4        already-shot bitmap, same layout as the map
//   acertos               hit count
//   tirosRestantes        shots left
//   estado                OCIOSO / JOGANDO / VITORIA / DERROTA
//   tiroAcerto/Agua/Invalido  one-cycle result pulses
//   bcdDezena/bcdUnidade  BCD of tirosRestantes (zero unless PLACAR_BCD_EN is defined)
// Build option: define PLACAR_BCD_EN to compile in the BCD converter.
module placar_jogo
  import placar_pkg::*;
#(
  parameter int unsigned MAX_TIROS = 15
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         confirmar,
  input  logic [2:0]   coordLinha,
  input  logic [2:0]   coordColuna,
  input  logic [6:0]   mapa0,
  input  logic [6:0]   mapa1,
  input  logic [6:0]   mapa2,
  input  logic [6:0]   mapa3,
  input  logic [6:0]   mapa4,
  output logic [6:0]   tiros0,
  output logic [6:0]   tiros1,
  output logic [6:0]   tiros2,
  output logic [6:0]   tiros3,
  output logic [6:0]   tiros4,
  output logic [5:0]   acertos,
  output logic [4:0]   tirosRestantes,
  output logic [1:0]   estado,
  output logic         tiroAcerto,
  output logic         tiroAgua,
  output logic         tiroInvalido,
  output logic [3:0]   bcdDezena,
  output logic [3:0]   bcdUnidade
);

  estado_t                estado_q, estado_n;
  logic [CELULAS-1:0]     tiros_q, tiros_n;
  logic [CONT_W-1:0]      acertos_n;
  logic [CONT_W-1:0]      navios_q, navios_n;
  logic [TIROS_W-1:0]     restantes_n;
  logic                   acerto_n, agua_n, invalido_n;

  logic                   disparo;
  logic [CELULAS-1:0]     mapa_flat;
  logic [CONT_W-1:0]      alvo_idx;
  logic [CELULAS-1:0]     alvo_mask;
  logic                   coord_ok, ja_atirado, alvo_navio;

  // Button edge detector; its history updates in every state.
  detector_borda u_borda_confirmar (
    .clock (clock),
    .reset (reset),
    .in    (confirmar),
    .pulse (disparo)
  );

  // Target cell decode; the mask is only meaningful when coord_ok.
  assign mapa_flat  = {mapa4, mapa3, mapa2, mapa1, mapa0};
  assign coord_ok   = (coordLinha < 3'(LINHAS)) && (coordColuna < 3'(COLUNAS));
  assign alvo_idx   = CONT_W'(coordColuna) * CONT_W'(LINHAS) + CONT_W'(coordLinha);
  assign alvo_mask  = {{(CELULAS-1){1'b0}}, 1'b1} << alvo_idx;
  assign ja_atirado = |(tiros_q & alvo_mask);
  assign alvo_navio = |(mapa_flat & alvo_mask);

  // Next-state and counter update.
  always_comb begin
    estado_n    = estado_q;
    tiros_n     = tiros_q;
    acertos_n   = acertos;
    restantes_n = tirosRestantes;
    navios_n    = navios_q;
    acerto_n    = 1'b0;
    agua_n      = 1'b0;
    invalido_n  = 1'b0;

    if (!enable) begin
      estado_n = OCIOSO;
    end else begin
      case (estado_q)
        OCIOSO: begin
          // New game: the map is sampled only here; a same-cycle press is dropped.
          estado_n    = JOGANDO;
          tiros_n     = '0;
          acertos_n   = '0;
          restantes_n = TIROS_W'(MAX_TIROS);
          navios_n    = popcount_mapa(mapa_flat);
        end
        JOGANDO: begin
          if (disparo) begin
            if (!coord_ok || ja_atirado) begin
              invalido_n = 1'b1;
            end else begin
              tiros_n     = tiros_q | alvo_mask;
              restantes_n = tirosRestantes - TIROS_W'(1);
              if (alvo_navio) begin
                acertos_n = acertos + CONT_W'(1);
                navios_n  = navios_q - CONT_W'(1);
                acerto_n  = 1'b1;
              end else begin
                agua_n = 1'b1;
              end
              // Sinking the last ship wins even when it used the last shot.
              if (navios_n == '0) begin
                estado_n = VITORIA;
              end else if (restantes_n == '0) begin
                estado_n = DERROTA;
              end
            end
          end else if (navios_q == '0) begin
            estado_n = VITORIA;
          end
        end
        VITORIA, DERROTA: begin
          estado_n = estado_q;
        end
        default: begin
          estado_n = OCIOSO;
        end
      endcase
    end
  end

  // State, bitmap, counters and result pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q       <= OCIOSO;
      tiros_q        <= '0;
      acertos        <= '0;
      tirosRestantes <= '0;
      navios_q       <= '0;
      tiroAcerto     <= 1'b0;
      tiroAgua       <= 1'b0;
      tiroInvalido   <= 1'b0;
    end else begin
      estado_q       <= estado_n;
      tiros_q        <= tiros_n;
      acertos        <= acertos_n;
      tirosRestantes <= restantes_n;
      navios_q       <= navios_n;
      tiroAcerto     <= acerto_n;
      tiroAgua       <= agua_n;
      tiroInvalido   <= invalido_n;
    end
  end

  assign estado = estado_q;
  assign tiros0 = tiros_q[0*LINHAS +: LINHAS];
  assign tiros1 = tiros_q[1*LINHAS +: LINHAS];
  assign tiros2 = tiros_q[2*LINHAS +: LINHAS];
  assign tiros3 = tiros_q[3*LINHAS +: LINHAS];
  assign tiros4 = tiros_q[4*LINHAS +: LINHAS];

`ifdef PLACAR_BCD_EN
  // Converted from the next count so the digits change on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      bcdDezena  <= 4'd0;
      bcdUnidade <= 4'd0;
    end else begin
      {bcdDezena, bcdUnidade} <= bcd_tiros(restantes_n);
    end
  end
`else
  assign bcdDezena  = 4'd0;
  assign bcdUnidade = 4'd0;
`endif

endmodule

// File: tb/tb_placar_jogo.sv
// tb_placar_jogo: directed test-plan scenarios followed by randomized play,
// every cycle compared against a game-rule reference model.
module tb_placar_jogo;

  localparam int MAXT = 15;

  logic       clock = 1'b0;
  logic       reset, enable, confirmar;
  logic [2:0] linha, coluna;
  logic [6:0] mp [5];
  logic [6:0] tr [5];
  logic [5:0] acertos;
  logic [4:0] restantes;
  logic [1:0] estado;
  logic       acerto_p, agua_p, invalido_p;
  logic [3:0] bcd_d, bcd_u;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit m_shot [5][7];
  int m_hits, m_left, m_ships, m_state;
  bit m_prev, m_hitp, m_miss, m_inv;

  always #5 clock = ~clock;

  placar_jogo #(.MAX_TIROS(MAXT)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .confirmar      (confirmar),
    .coordLinha     (linha),
    .coordColuna    (coluna),
    .mapa0          (mp[0]),
    .mapa1          (mp[1]),
    .mapa2          (mp[2]),
    .mapa3          (mp[3]),
    .mapa4          (mp[4]),
    .tiros0         (tr[0]),
    .tiros1         (tr[1]),
    .tiros2         (tr[2]),
    .tiros3         (tr[3]),
    .tiros4         (tr[4]),
    .acertos        (acertos),
    .tirosRestantes (restantes),
    .estado         (estado),
    .tiroAcerto     (acerto_p),
    .tiroAgua       (agua_p),
    .tiroInvalido   (invalido_p),
    .bcdDezena      (bcd_d),
    .bcdUnidade     (bcd_u)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_shots();
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 7; r++)
        m_shot[c][r] = 1'b0;
  endtask

  // One clock edge of the game rules, using the inputs about to be sampled.
  task automatic model_step();
    bit disp;
    int r, c;
    disp   = confirmar && !m_prev;
    m_prev = confirmar;
    m_hitp = 0; m_miss = 0; m_inv = 0;
    r = int'(linha);
    c = int'(coluna);
    if (reset) begin
      m_state = 0; m_hits = 0; m_left = 0; m_ships = 0; m_prev = 0;
      clear_shots();
      return;
    end
    if (!enable) begin
      m_state = 0;
      return;
    end
    case (m_state)
      0: begin
        m_state = 1; m_hits = 0; m_left = MAXT; m_ships = 0;
        clear_shots();
        for (int cc = 0; cc < 5; cc++)
          for (int rr = 0; rr < 7; rr++)
            if (mp[cc][rr]) m_ships++;
      end
      1: begin
        if (disp) begin
          if (r > 6 || c > 4) m_inv = 1;
          else if (m_shot[c][r]) m_inv = 1;
          else begin
            m_shot[c][r] = 1;
            m_left--;
            if (mp[c][r]) begin m_hits++; m_ships--; m_hitp = 1; end
            else m_miss = 1;
            if (m_ships == 0) m_state = 2;
            else if (m_left == 0) m_state = 3;
          end
        end else if (m_ships == 0) begin
          m_state = 2;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    logic [6:0] col;
    check("estado", 32'(estado), 32'(m_state));
    check("acertos", 32'(acertos), 32'(m_hits));
    check("restantes", 32'(restantes), 32'(m_left));
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < 7; r++) col[r] = m_shot[c][r];
      check($sformatf("tiros%0d", c), 32'(tr[c]), 32'(col));
    end
    check("tiroAcerto", 32'(acerto_p), 32'(m_hitp));
    check("tiroAgua", 32'(agua_p), 32'(m_miss));
    check("tiroInvalido", 32'(invalido_p), 32'(m_inv));
`ifdef PLACAR_BCD_EN
    check("bcdDezena", 32'(bcd_d), 32'(m_left / 10));
    check("bcdUnidade", 32'(bcd_u), 32'(m_left % 10));
`else
    check("bcdDezena", 32'(bcd_d), 32'd0);
    check("bcdUnidade", 32'(bcd_u), 32'd0);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic press(input int r, input int c);
    linha = 3'(r); coluna = 3'(c); confirmar = 1'b1;
    tick();
  endtask

  task automatic release_btn();
    confirmar = 1'b0;
    tick();
  endtask

  task automatic clear_map();
    for (int c = 0; c < 5; c++) mp[c] = 7'd0;
  endtask

  initial begin
    int k;
    reset = 1'b1; enable = 1'b1; confirmar = 1'b1; linha = 3'd0; coluna = 3'd0;
    m_prev = 0; m_state = 0; m_hits = 0; m_left = 0; m_ships = 0;
    clear_shots();
    clear_map();
    mp[3] = 7'b0000100;

    // Reset dominates enable and a held button
    tick(); tick();
    check("rst_estado", 32'(estado), 32'd0);
    reset = 1'b0;
    tick();
    check("load_estado", 32'(estado), 32'd1);
    check("load_restantes", 32'(restantes), 32'd15);
`ifdef PLACAR_BCD_EN
    check("load_bcd", 32'({bcd_d, bcd_u}), 32'h15);
`endif
    release_btn();

    // Single ship sunk: hit and victory on the same edge
    press(2, 3);
    check("hit_pulse", 32'(acerto_p), 32'd1);
    check("hit_estado", 32'(estado), 32'd2);
    check("hit_tiros3", 32'(tr[3]), 32'h04);
    release_btn();
    enable = 1'b0;
    tick();
    check("idle_estado", 32'(estado), 32'd0);
    check("idle_acertos", 32'(acertos), 32'd1);

    // Miss, repeat (invalid), out-of-range (invalid), then defeat
    clear_map();
    mp[4] = 7'b1000000;
    enable = 1'b1;
    tick();
    press(0, 0);
    check("miss_pulse", 32'(agua_p), 32'd1);
    check("miss_restantes", 32'(restantes), 32'd14);
    release_btn();
    press(0, 0);
    check("repeat_inv", 32'(invalido_p), 32'd1);
    check("repeat_restantes", 32'(restantes), 32'd14);
    release_btn();
    press(7, 4);
    check("range_inv", 32'(invalido_p), 32'd1);
    release_btn();
    k = 0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 4; c++)
        if (k < 14 && !(r == 0 && c == 0)) begin
          press(r, c); release_btn(); k++;
        end
    check("defeat_estado", 32'(estado), 32'd3);
    press(6, 4);
    check("defeat_nopulse", 32'({acerto_p, agua_p, invalido_p}), 32'd0);
    release_btn();

    // Last shot sinks the last ship: victory wins over zero shots
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    k = 0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 4; c++)
        if (k < 14) begin
          press(r, c); release_btn(); k++;
        end
    press(6, 4);
    check("last_estado", 32'(estado), 32'd2);
    check("last_restantes", 32'(restantes), 32'd0);
    release_btn();
    enable = 1'b0; tick();
    check("hold_estado", 32'(estado), 32'd0);
    check("hold_acertos", 32'(acertos), 32'd1);

    // Empty map: victory one cycle after the load
    clear_map();
    enable = 1'b1; tick();
    tick();
    check("empty_victory", 32'(estado), 32'd2);

    // Button already held when enable rises gives no shot
    enable = 1'b0; mp[1] = 7'b0011000; confirmar = 1'b1; linha = 3'd3; coluna = 3'd1;
    tick(); tick();
    enable = 1'b1; tick(); tick(); tick();
    release_btn();

    // Randomized play
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (enable) enable = ($urandom_range(0, 59) != 0);
      else        enable = ($urandom_range(0, 3) == 0);
      confirmar = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) begin
        linha = 3'($urandom_range(0, 7)); coluna = 3'($urandom_range(0, 7));
      end else begin
        linha = 3'($urandom_range(0, 6)); coluna = 3'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 49) == 0)
        for (int c = 0; c < 5; c++)
          for (int r = 0; r < 7; r++)
            mp[c][r] = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
